// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl: arbitrates the CPU data port and instruction-fetch port onto one memory bus.
// A grant latches the request into registered bus outputs. The strobe stays up while bus_full
// holds the request state. The captured read data or the write completion is reported by a
// one-cycle valid pulse.
// Optional build macro: MEMCTRL_TIMEOUT_EN. When it is defined, a request state aborts with an
// err pulse after TIMEOUT consecutive bus_full cycles. Without it, err is tied low and the
// controller waits indefinitely.
module mem_arb_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,  // must be a multiple of 8
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_en,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [ADDR_W-1:0]     address_in,
  input  logic [DATA_W-1:0]     data_in_CPU,
  input  logic [DATA_W/8-1:0]   byte_en,
  input  logic                  instr_en,
  input  logic [ADDR_W-1:0]     pc_in,
  input  logic [DATA_W-1:0]     data_in_BUS,
  input  logic                  bus_full,
  output logic [2:0]            state,
  output logic [ADDR_W-1:0]     address_out,
  output logic [DATA_W-1:0]     data_out_BUS,
  output logic [DATA_W/8-1:0]   byte_sel,
  output logic                  bus_read,
  output logic                  bus_write,
  output logic [DATA_W-1:0]     data_out_CPU,
  output logic [DATA_W-1:0]     data_out_INSTR,
  output logic                  data_valid,
  output logic                  instr_valid,
  output logic                  err,
  output logic                  cpu_stall
);

  localparam int unsigned BeW = DATA_W / 8;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRdReq = 3'd1,
    StWrReq = 3'd2,
    StRead  = 3'd3,
    StWrite = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;  // 1: instruction port was granted last
  logic                src_instr_q, src_instr_d;    // source of the transaction in flight
  logic [ADDR_W-1:0]   address_out_q, address_out_d;
  logic [DATA_W-1:0]   data_out_bus_q, data_out_bus_d;
  logic [BeW-1:0]      byte_sel_q, byte_sel_d;
  logic                bus_read_q, bus_read_d;
  logic                bus_write_q, bus_write_d;
  logic [DATA_W-1:0]   data_out_cpu_q, data_out_cpu_d;
  logic [DATA_W-1:0]   data_out_instr_q, data_out_instr_d;
  logic                data_valid_q, data_valid_d;
  logic                instr_valid_q, instr_valid_d;

  logic req_state;
  logic data_pend;
  logic grant_data;
  logic timeout_hit;

  assign req_state  = (state_q == StRdReq) || (state_q == StWrReq);
  // data_en without a read or write strobe is not a request.
  assign data_pend  = data_en && (memRead || memWrite);
  // On a tie, the port that was not granted last wins.
  assign grant_data = data_pend && (!instr_en || last_grant_q);

`ifdef MEMCTRL_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CntW-1:0] busy_cnt_q, busy_cnt_d;
  logic            err_q;

  // The abort fires on the TIMEOUT-th consecutive stalled cycle of a request state.
  assign timeout_hit = req_state && bus_full && (busy_cnt_q == CntMax);

  // Count consecutive stalled cycles; any state change restarts the run.
  always_comb begin
    busy_cnt_d = '0;
    if (req_state && bus_full && !timeout_hit) begin
      busy_cnt_d = busy_cnt_q + 1'b1;
    end
  end

  // Stall counter and the one-cycle error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
      err_q      <= timeout_hit;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // Next-state and next-output decode for the arbiter FSM.
  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    src_instr_d      = src_instr_q;
    address_out_d    = address_out_q;
    data_out_bus_d   = data_out_bus_q;
    byte_sel_d       = byte_sel_q;
    bus_read_d       = bus_read_q;
    bus_write_d      = bus_write_q;
    data_out_cpu_d   = data_out_cpu_q;
    data_out_instr_d = data_out_instr_q;
    data_valid_d     = 1'b0;
    instr_valid_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (grant_data) begin
          last_grant_d  = 1'b0;
          src_instr_d   = 1'b0;
          address_out_d = address_in;
          // A request with both strobes set is treated as a write.
          if (memWrite) begin
            state_d        = StWrReq;
            bus_write_d    = 1'b1;
            data_out_bus_d = data_in_CPU;
            byte_sel_d     = byte_en;
          end else begin
            state_d        = StRdReq;
            bus_read_d     = 1'b1;
            data_out_bus_d = '0;
            byte_sel_d     = '1;
          end
        end else if (instr_en) begin
          last_grant_d   = 1'b1;
          src_instr_d    = 1'b1;
          address_out_d  = pc_in;
          state_d        = StRdReq;
          bus_read_d     = 1'b1;
          data_out_bus_d = '0;
          byte_sel_d     = '1;
        end
      end

      StRdReq, StWrReq: begin
        if (timeout_hit || !bus_full) begin
          if (timeout_hit) begin
            state_d = StIdle;
          end else if (state_q == StRdReq) begin
            state_d = StRead;
          end else begin
            state_d = StWrite;
          end
          bus_read_d     = 1'b0;
          bus_write_d    = 1'b0;
          address_out_d  = '0;
          data_out_bus_d = '0;
          byte_sel_d     = '0;
        end
      end

      StRead: begin
        if (src_instr_q) begin
          data_out_instr_d = data_in_BUS;
          instr_valid_d    = 1'b1;
        end else begin
          data_out_cpu_d = data_in_BUS;
          data_valid_d   = 1'b1;
        end
        state_d = StIdle;
      end

      StWrite: begin
        data_valid_d = 1'b1;
        state_d      = StIdle;
      end

      // Unused encodings recover to IDLE with the bus released.
      default: begin
        state_d        = StIdle;
        bus_read_d     = 1'b0;
        bus_write_d    = 1'b0;
        address_out_d  = '0;
        data_out_bus_d = '0;
        byte_sel_d     = '0;
      end
    endcase
  end

  // FSM state, arbitration history and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      last_grant_q     <= 1'b1;  // data port wins the first tie
      src_instr_q      <= 1'b0;
      address_out_q    <= '0;
      data_out_bus_q   <= '0;
      byte_sel_q       <= '0;
      bus_read_q       <= 1'b0;
      bus_write_q      <= 1'b0;
      data_out_cpu_q   <= '0;
      data_out_instr_q <= '0;
      data_valid_q     <= 1'b0;
      instr_valid_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      src_instr_q      <= src_instr_d;
      address_out_q    <= address_out_d;
      data_out_bus_q   <= data_out_bus_d;
      byte_sel_q       <= byte_sel_d;
      bus_read_q       <= bus_read_d;
      bus_write_q      <= bus_write_d;
      data_out_cpu_q   <= data_out_cpu_d;
      data_out_instr_q <= data_out_instr_d;
      data_valid_q     <= data_valid_d;
      instr_valid_q    <= instr_valid_d;
    end
  end

  assign state          = state_q;
  assign address_out    = address_out_q;
  assign data_out_BUS   = data_out_bus_q;
  assign byte_sel       = byte_sel_q;
  assign bus_read       = bus_read_q;
  assign bus_write      = bus_write_q;
  assign data_out_CPU   = data_out_cpu_q;
  assign data_out_INSTR = data_out_instr_q;
  assign data_valid     = data_valid_q;
  assign instr_valid    = instr_valid_q;
  assign cpu_stall      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Bench for mem_arb_ctrl.
// The bus slave is a memory model that returns read data one cycle after it accepts a request.
// The reference model applies round-robin order and memory semantics and queues the expected
// bus phases and responses. A monitor pops and compares them when the DUT presents them.
module tb_mem_arb_ctrl;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          data_en, memRead, memWrite, instr_en, bus_full;
  logic [AW-1:0] address_in, pc_in;
  logic [DW-1:0] data_in_CPU, data_in_BUS;
  logic [BW-1:0] byte_en;
  logic [2:0]    state;
  logic [AW-1:0] address_out;
  logic [DW-1:0] data_out_BUS, data_out_CPU, data_out_INSTR;
  logic [BW-1:0] byte_sel;
  logic          bus_read, bus_write, data_valid, instr_valid, err, cpu_stall;

  mem_arb_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .data_en(data_en), .memRead(memRead), .memWrite(memWrite),
    .address_in(address_in), .data_in_CPU(data_in_CPU), .byte_en(byte_en),
    .instr_en(instr_en), .pc_in(pc_in), .data_in_BUS(data_in_BUS), .bus_full(bus_full),
    .state(state), .address_out(address_out), .data_out_BUS(data_out_BUS),
    .byte_sel(byte_sel), .bus_read(bus_read), .bus_write(bus_write),
    .data_out_CPU(data_out_CPU), .data_out_INSTR(data_out_INSTR), .data_valid(data_valid),
    .instr_valid(instr_valid), .err(err), .cpu_stall(cpu_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
  } bus_t;

  typedef struct {
    bit            is_instr;
    bit            is_wr;
    logic [DW-1:0] rdata;
  } rsp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] ref_mem[logic [AW-1:0]];
  logic [DW-1:0] slv_mem[logic [AW-1:0]];
  bit            ref_last = 1'b1;  // 1: instruction granted last
  logic [DW-1:0] exp_cpu = '0;
  logic [DW-1:0] exp_instr = '0;
  bit            force_busy = 1'b0;
  bit            to_mode = 1'b0;
  int            mon_cyc = 0;
  int            mon_acc_cyc = -100;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endfunction

  function automatic logic [DW-1:0] dflt(logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = a * 32'h9E37_79B1;
    return v ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] wd,
                                          logic [BW-1:0] be);
    for (int b = 0; b < int'(BW); b++) begin
      if (be[b]) old[8*b +: 8] = wd[8*b +: 8];
    end
    return old;
  endfunction

  function automatic logic [DW-1:0] ref_rd(logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [DW-1:0] slv_rd(logic [AW-1:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : dflt(a);
  endfunction

  // Reference model: one granted data-port transaction.
  function automatic void model_data(bit wr, logic [AW-1:0] a, logic [BW-1:0] be,
                                     logic [DW-1:0] wd);
    bus_t b;
    rsp_t r;
    b.is_wr = wr; b.addr = a; b.be = wr ? be : '1; b.wdata = wd;
    r.is_instr = 1'b0; r.is_wr = wr; r.rdata = '0;
    if (wr) ref_mem[a] = merge(ref_rd(a), wd, be);
    else r.rdata = ref_rd(a);
    bus_q.push_back(b);
    rsp_q.push_back(r);
    ref_last = 1'b0;
  endfunction

  // Reference model: one granted instruction fetch.
  function automatic void model_instr(logic [AW-1:0] a);
    bus_t b;
    rsp_t r;
    b.is_wr = 1'b0; b.addr = a; b.be = '1; b.wdata = '0;
    r.is_instr = 1'b1; r.is_wr = 1'b0; r.rdata = ref_rd(a);
    bus_q.push_back(b);
    rsp_q.push_back(r);
    ref_last = 1'b1;
  endfunction

  // Bus slave: accepts when a strobe is up and bus_full is low; read data follows a cycle later.
  initial begin
    bit            acc_rd, acc_wr;
    logic [DW-1:0] nxt;
    int            busy_run;
    busy_run = 0;
    nxt = '0;
    bus_full = 1'b0;
    data_in_BUS = '0;
    forever begin
      @(negedge clk);
      acc_rd = !rst && bus_read && !bus_full;
      acc_wr = !rst && bus_write && !bus_full;
      if (acc_wr) slv_mem[address_out] = merge(slv_rd(address_out), data_out_BUS, byte_sel);
      if (acc_rd) nxt = slv_rd(address_out);
      @(posedge clk);
      #1;
      data_in_BUS = acc_rd ? nxt : DW'($urandom);
      if (force_busy) bus_full = 1'b1;
      else if (busy_run >= 4) bus_full = 1'b0;
      else bus_full = ($urandom_range(0, 2) == 0);
      busy_run = bus_full ? busy_run + 1 : 0;
    end
  end

  // Monitor: compares bus phases and completions against the scoreboard queues.
  initial begin
    bus_t b;
    rsp_t r;
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (!rst) begin
        chk("stall_vs_state", 64'(cpu_stall), 64'(state != 3'd0));
        chk("state_legal", 64'(state <= 3'd4), 64'(1));
        if (err && !to_mode) chk("err_spurious", 64'(err), 64'(0));
        if ((bus_read || bus_write) && !bus_full) begin
          chk("strobe_exclusive", 64'(bus_read && bus_write), 64'(0));
          if (bus_q.size() == 0) begin
            chk("accept_unexpected", 64'(bus_q.size()), 64'(1));
          end else begin
            b = bus_q.pop_front();
            chk("bus_kind", 64'(bus_write), 64'(b.is_wr));
            chk("bus_addr", 64'(address_out), 64'(b.addr));
            chk("bus_bytesel", 64'(byte_sel), 64'(b.be));
            if (b.is_wr) chk("bus_wdata", 64'(data_out_BUS), 64'(b.wdata));
            mon_acc_cyc = mon_cyc;
          end
        end
        if (data_valid || instr_valid) begin
          chk("valid_onehot", 64'(data_valid && instr_valid), 64'(0));
          if (rsp_q.size() == 0) begin
            chk("valid_unexpected", 64'(rsp_q.size()), 64'(1));
          end else begin
            r = rsp_q.pop_front();
            chk("valid_src", 64'(instr_valid), 64'(r.is_instr));
            chk("valid_latency", 64'(mon_cyc - mon_acc_cyc), 64'(2));
            if (r.is_instr) exp_instr = r.rdata;
            else if (!r.is_wr) exp_cpu = r.rdata;
            chk("data_out_cpu", 64'(data_out_CPU), 64'(exp_cpu));
            chk("data_out_instr", 64'(data_out_INSTR), 64'(exp_instr));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!cpu_stall && n < 40);
    chk("grant_seen", 64'(cpu_stall), 64'(1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cpu_stall && n < 60) begin
      tick();
      n++;
    end
    if (cpu_stall) chk("idle_timeout", 64'(cpu_stall), 64'(0));
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_state"}, 64'(state), 64'(0));
    chk({tag, "_addr"}, 64'(address_out), 64'(0));
    chk({tag, "_wdata"}, 64'(data_out_BUS), 64'(0));
    chk({tag, "_bytesel"}, 64'(byte_sel), 64'(0));
    chk({tag, "_bus_read"}, 64'(bus_read), 64'(0));
    chk({tag, "_bus_write"}, 64'(bus_write), 64'(0));
    chk({tag, "_cpu_out"}, 64'(data_out_CPU), 64'(0));
    chk({tag, "_instr_out"}, 64'(data_out_INSTR), 64'(0));
    chk({tag, "_data_valid"}, 64'(data_valid), 64'(0));
    chk({tag, "_instr_valid"}, 64'(instr_valid), 64'(0));
    chk({tag, "_err"}, 64'(err), 64'(0));
    chk({tag, "_stall"}, 64'(cpu_stall), 64'(0));
  endtask

  task automatic deassert();
    data_en = 1'b0; memRead = 1'b0; memWrite = 1'b0; instr_en = 1'b0;
  endtask

  // Issue a request set, hold it until every expected grant is seen, then release it.
  task automatic issue(input bit dreq, input bit dwr, input bit ireq,
                       input logic [AW-1:0] da, input logic [AW-1:0] ia);
    logic [DW-1:0] wd;
    logic [BW-1:0] be;
    int            ng;
    wd = DW'($urandom);
    be = BW'($urandom);
    ng = int'(dreq) + int'(ireq);
    if (dreq && ireq && ref_last) begin
      model_data(dwr, da, be, wd);
      model_instr(ia);
    end else if (dreq && ireq) begin
      model_instr(ia);
      model_data(dwr, da, be, wd);
    end else if (dreq) begin
      model_data(dwr, da, be, wd);
    end else if (ireq) begin
      model_instr(ia);
    end
    data_en     = dreq || ($urandom_range(0, 3) == 0);
    memWrite    = dreq && dwr;
    memRead     = dreq && (!dwr || ($urandom_range(0, 1) == 1));
    address_in  = da;
    data_in_CPU = wd;
    byte_en     = be;
    instr_en    = ireq;
    pc_in       = ia;
    if (ng == 0) begin
      repeat (3) begin
        tick();
        chk("no_req_state", 64'(state), 64'(0));
        chk("no_req_stall", 64'(cpu_stall), 64'(0));
      end
    end
    for (int g = 0; g < ng; g++) begin
      wait_idle();
      wait_grant();
    end
    deassert();
    wait_idle();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return 32'h100 + AW'({$urandom_range(0, 7), 2'b00});
  endfunction

  initial begin
    int k;
    int n;
    rst = 1'b1;
    deassert();
    address_in = '0; data_in_CPU = '0; byte_en = '0; pc_in = '0;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Tie straight after reset: data first, then instruction.
    issue(1'b1, 1'b0, 1'b1, 32'h100, 32'h104);

    for (int t = 0; t < 200; t++) begin
      k = $urandom_range(0, 9);
      issue(k <= 3 || k >= 7, $urandom_range(0, 1) == 1, k >= 4 && k <= 8,
            rand_addr(), rand_addr());
    end

    // Reset while a read is stalled in its request state.
    force_busy = 1'b1;
    repeat (2) tick();
    data_en = 1'b1; memRead = 1'b1; address_in = 32'h140;
    model_data(1'b0, 32'h140, '0, '0);
    wait_grant();
    chk("pre_reset_state", 64'(state), 64'(1));
    chk("pre_reset_read", 64'(bus_read), 64'(1));
    rst = 1'b1;
    deassert();
    bus_q.delete();
    rsp_q.delete();
    ref_last = 1'b1;
    exp_cpu = '0;
    exp_instr = '0;
    tick();
    check_zero("mid_reset");
    rst = 1'b0;
    force_busy = 1'b0;
    repeat (4) tick();

    // Reset must reseed round-robin so data wins again.
    issue(1'b1, 1'b1, 1'b1, 32'h108, 32'h10c);
    issue(1'b1, 1'b0, 1'b1, 32'h108, 32'h110);

`ifdef MEMCTRL_TIMEOUT_EN
    force_busy = 1'b1;
    to_mode = 1'b1;
    repeat (2) tick();
    data_en = 1'b1; memRead = 1'b1; address_in = 32'h118;
    wait_grant();
    deassert();
    n = 0;
    while (!err && n < 40) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 64'(n), 64'(TO));
    chk("timeout_state", 64'(state), 64'(0));
    chk("timeout_strobe", 64'(bus_read), 64'(0));
    tick();
    chk("timeout_pulse", 64'(err), 64'(0));
    to_mode = 1'b0;
    force_busy = 1'b0;
    repeat (3) tick();
`endif

    n = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < 20) begin
      tick();
      n++;
    end
    chk("drain_rsp", 64'(rsp_q.size()), 64'(0));
    chk("drain_bus", 64'(bus_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
